// File: rtl/lcd_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : lcd_pkg                                                    |
// | Purpose : Shared types and helpers for the HD44780 bus arbiter:      |
// |           FSM state encoding, LCD command constants and the          |
// |           long-settle command classifier.                            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package lcd_pkg;

  // Arbiter FSM states; each state describes the registered bus outputs
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI_EN = 3'd1,
    ST_HI_LO = 3'd2,
    ST_LO_EN = 3'd3,
    ST_LO_LO = 3'd4,
    ST_WAIT  = 3'd5
  } lcd_arb_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear and the two home encodings need the long settle time
  function automatic logic lcd_is_long_cmd(input logic rs_val, input logic [7:0] byte_val);
    return !rs_val && ((byte_val == LCD_CMD_CLEAR) ||
                       (byte_val == LCD_CMD_HOME)  ||
                       (byte_val == 8'h03));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : lcd_bus_arbiter_if                                       |
// | Purpose   : Requester-side handshake plus LCD pin bundle for the     |
// |             arbiter. master = requesters/pins view, slave = arbiter. |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface lcd_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   rs_in;
  logic [NUM_REQ-1:0]   nib_in;
  logic [8*NUM_REQ-1:0] byte_in;
  logic [NUM_REQ-1:0]   lock;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic                 en;
  logic                 rs;
  logic [3:0]           data;

  modport master (
    output req, rs_in, nib_in, byte_in, lock,
    input  ack, busy, en, rs, data
  );

  modport slave (
    input  req, rs_in, nib_in, byte_in, lock,
    output ack, busy, en, rs, data
  );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lcd_rr_arbiter                                             |
// | Purpose : Combinational round-robin pick. Search starts one past the |
// |           previous winner; a valid lock forces the previous winner.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lcd_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [IW-1:0]      last,
  input  wire logic               lock_valid,
  output logic      [NUM_REQ-1:0] grant,
  output logic      [IW-1:0]      grant_idx,
  output logic                    grant_valid
);

  logic [IW-1:0] cand_idx;

  // Walk the requesters in rotating order and take the first one asserted
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    if (lock_valid) begin
      grant[last] = 1'b1;
      grant_idx   = last;
      grant_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand_idx = IW'((int'(last) + k) % NUM_REQ);
        if (!grant_valid && req[cand_idx]) begin
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
          grant_valid     = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lcd_bus_arbiter                                            |
// | Purpose : Shares the HD44780 4-bit bus between NUM_REQ byte-write    |
// |           requesters. Round-robin grant, high/low nibble E pulses,   |
// |           then a settle delay chosen by command type.                |
// | Config  : LCD_ARB_LOCK_EN - previous winner keeps the bus while its  |
// |           lock and req are both high (atomic multi-byte sequences).  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int SHORT_DELAY  = 0,
  parameter int LONG_DELAY   = 2,
  parameter int NIBBLE_DELAY = 5
) (
  input wire logic          clk,
  input wire logic          reset,
  lcd_bus_arbiter_if.slave  bus
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int MAX_SL  = (SHORT_DELAY > LONG_DELAY) ? SHORT_DELAY : LONG_DELAY;
  localparam int MAX_DLY = (MAX_SL > NIBBLE_DELAY) ? MAX_SL : NIBBLE_DELAY;
  localparam int CW      = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);

  localparam logic [CW-1:0] C_SHORT  = CW'(SHORT_DELAY);
  localparam logic [CW-1:0] C_LONG   = CW'(LONG_DELAY);
  localparam logic [CW-1:0] C_NIBBLE = CW'(NIBBLE_DELAY);
  localparam logic [IW-1:0] C_LAST_RST = IW'(NUM_REQ - 1);

`ifdef LCD_ARB_LOCK_EN
  localparam logic C_LOCK_EN = 1'b1;
`else
  localparam logic C_LOCK_EN = 1'b0;
`endif

  lcd_arb_state_t     state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         byte_q, byte_d;
  logic               nib_q, nib_d;
  logic               rs_q, rs_d;
  logic [3:0]         data_q, data_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic               lock_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [7:0]         pick_byte;
  logic [CW-1:0]      delay_sel;

  // With the lock feature compiled out the lock inputs are masked to zero
  assign lock_valid = C_LOCK_EN & bus.lock[last_q] & bus.req[last_q];
  assign pick_byte  = bus.byte_in[8*pick_idx +: 8];

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req         (bus.req),
    .last        (last_q),
    .lock_valid  (lock_valid),
    .grant       (pick_grant),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // Settle time for the byte in flight; nibble-only beats command class
  always_comb begin
    delay_sel = C_SHORT;
    if (nib_q) begin
      delay_sel = C_NIBBLE;
    end else if (lcd_is_long_cmd(rs_q, byte_q)) begin
      delay_sel = C_LONG;
    end
  end

  // Next-state and next-output logic; outputs are pre-computed for the flops
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    nib_d   = nib_q;
    rs_d    = rs_q;
    data_d  = data_q;
    en_d    = 1'b0;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ack_d  = pick_grant;
          last_d = pick_idx;
          rs_d   = bus.rs_in[pick_idx];
          nib_d  = bus.nib_in[pick_idx];
          byte_d = pick_byte;
          en_d   = 1'b1;
          if (bus.nib_in[pick_idx]) begin
            data_d  = pick_byte[3:0];
            state_d = ST_LO_EN;
          end else begin
            data_d  = pick_byte[7:4];
            state_d = ST_HI_EN;
          end
        end
      end
      ST_HI_EN: state_d = ST_HI_LO;
      ST_HI_LO: begin
        en_d    = 1'b1;
        data_d  = byte_q[3:0];
        state_d = ST_LO_EN;
      end
      ST_LO_EN: state_d = ST_LO_LO;
      ST_LO_LO: begin
        if (delay_sel == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = delay_sel;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter only counts down and stops at zero
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any byte in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= C_LAST_RST;
      cnt_q   <= '0;
      byte_q  <= '0;
      nib_q   <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;
  assign bus.en   = en_q;
  assign bus.rs   = rs_q;
  assign bus.data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_lcd_bus_arbiter                                         |
// | Purpose : Directed self-checking bench for lcd_bus_arbiter, two      |
// |           requesters, default delays (short 0, long 2, nibble 5).    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_lcd_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_g [4];

  lcd_bus_arbiter_if #(.NUM_REQ(2)) bus ();

  lcd_bus_arbiter #(
    .NUM_REQ      (2),
    .SHORT_DELAY  (0),
    .LONG_DELAY   (2),
    .NIBBLE_DELAY (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.req     = '0;
    bus.rs_in   = '0;
    bus.nib_in  = '0;
    bus.byte_in = '0;
    bus.lock    = '0;
    tick(); tick(); tick();
    reset = 1'b0;

    // reset values
    chk("rst_en",   32'(bus.en),   0);
    chk("rst_rs",   32'(bus.rs),   0);
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_ack",  32'(bus.ack),  0);
    chk("rst_busy", 32'(bus.busy), 0);

    // single data byte 0x48 from requester 0 (cycle T = now)
    bus.req[0] = 1'b1; bus.rs_in[0] = 1'b1; bus.byte_in[7:0] = 8'h48;
    tick();  // T+1
    chk("b1_ack",  32'(bus.ack),  32'h1);
    chk("b1_en1",  32'(bus.en),   1);
    chk("b1_hi",   32'(bus.data), 4);
    chk("b1_rs",   32'(bus.rs),   1);
    chk("b1_busy", 32'(bus.busy), 1);
    bus.req[0] = 1'b0;
    tick();  // T+2
    chk("b1_en2",  32'(bus.en),   0);
    chk("b1_ack2", 32'(bus.ack),  0);
    tick();  // T+3
    chk("b1_en3",  32'(bus.en),   1);
    chk("b1_lo",   32'(bus.data), 8);
    tick();  // T+4
    chk("b1_en4",  32'(bus.en),   0);
    chk("b1_hold", 32'(bus.data), 8);
    tick();  // T+5
    chk("b1_idle", 32'(bus.busy), 0);

    // two requesters held continuously after a fresh reset: 0,1,0,1
    reset = 1'b1; tick(); reset = 1'b0;
    bus.byte_in = 16'h7241; bus.rs_in = 2'b11; bus.req = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if ((c % 5) == 1) begin
        chk("rr_ack", 32'(bus.ack), (((c / 5) % 2) == 0) ? 32'h1 : 32'h2);
        chk("rr_hi",  32'(bus.data), (((c / 5) % 2) == 0) ? 32'h4 : 32'h7);
      end else begin
        chk("rr_noack", 32'(bus.ack), 0);
      end
      if (c == 16) bus.req = 2'b00;
    end
    tick();
    chk("rr_idle", 32'(bus.busy), 0);

    // clear command from requester 1: two WAIT cycles, next grant at T+8
    bus.req = 2'b10; bus.rs_in = 2'b01; bus.byte_in = 16'h0148;
    tick();  // T+1
    chk("clr_ack", 32'(bus.ack),  32'h2);
    chk("clr_rs",  32'(bus.rs),   0);
    chk("clr_hi",  32'(bus.data), 0);
    bus.req = 2'b01;
    tick(); tick();  // T+3
    chk("clr_lo",    32'(bus.data), 1);
    tick(); tick();  // T+5
    chk("clr_wait1", 32'(bus.busy), 1);
    tick();          // T+6
    chk("clr_wait2", 32'(bus.busy), 1);
    tick();          // T+7
    chk("clr_idle",  32'(bus.busy), 0);
    chk("clr_noack", 32'(bus.ack),  0);
    tick();          // T+8
    chk("clr_next",  32'(bus.ack),  32'h1);
    chk("clr_nrs",   32'(bus.rs),   1);
    bus.req = 2'b00;
    tick(); tick(); tick(); tick(); tick();

    // nibble-only 0x03 from requester 0 (rs=0): one E pulse, 5 WAIT cycles
    bus.req = 2'b01; bus.nib_in = 2'b01; bus.rs_in = 2'b00; bus.byte_in = 16'h0003;
    tick();  // T+1
    chk("nib_ack",  32'(bus.ack),  32'h1);
    chk("nib_en",   32'(bus.en),   1);
    chk("nib_data", 32'(bus.data), 3);
    bus.req = 2'b00;
    tick();  // T+2
    chk("nib_en2",  32'(bus.en),   0);
    tick();  // T+3
    chk("nib_en3",  32'(bus.en),   0);
    chk("nib_w1",   32'(bus.busy), 1);
    tick(); tick(); tick(); tick();  // T+7
    chk("nib_w5",   32'(bus.busy), 1);
    tick();  // T+8
    chk("nib_idle", 32'(bus.busy), 0);
    bus.nib_in = 2'b00;

    // reset in HI_LO drops the byte; held request restarts on high nibble
    bus.req = 2'b01; bus.rs_in = 2'b01; bus.byte_in = 16'h0048;
    tick(); tick();  // T+2, in HI_LO
    chk("rmid_lo", 32'(bus.en), 0);
    reset = 1'b1;
    tick();          // T+3
    chk("rmid_en",   32'(bus.en),   0);
    chk("rmid_busy", 32'(bus.busy), 0);
    chk("rmid_data", 32'(bus.data), 0);
    reset = 1'b0;
    tick();          // T+4
    chk("rmid_ack",  32'(bus.ack),  32'h1);
    chk("rmid_hi",   32'(bus.data), 4);
    bus.req = 2'b00;
    tick(); tick(); tick(); tick();

    // lock on requester 0 with requester 1 pending
`ifdef LCD_ARB_LOCK_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`endif
    bus.byte_in = 16'h7241; bus.rs_in = 2'b11; bus.lock = 2'b01; bus.req = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if ((c % 5) == 1) begin
        chk("lock_ack", 32'(bus.ack), 32'(exp_g[c / 5]));
      end else if ((c % 5) == 3) begin
        chk("lock_noack", 32'(bus.ack), 0);
      end
      if (c == 11) bus.lock = 2'b00;
      if (c == 16) bus.req = 2'b00;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
